// File: rtl/data_mem_bridge_if.sv
// Signals between the core memory stage, data_mem_bridge and the data RAM.
// The slave modport is the bridge's view; master is the environment (core plus RAM).
interface data_mem_bridge_if;
    logic        req;
    logic        wr;
    logic [1:0]  width;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        m_valid;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    modport slave (
        input  req, wr, width, sgn, addr, wdata, m_ready, m_rvalid, m_rdata,
        output ack, err, rdata, m_valid, m_we, m_be, m_addr, m_wdata
    );

    modport master (
        output req, wr, width, sgn, addr, wdata, m_ready, m_rvalid, m_rdata,
        input  ack, err, rdata, m_valid, m_we, m_be, m_addr, m_wdata
    );
endinterface

// File: rtl/data_mem_bridge.sv
// Byte/half/word load-store bridge from the core memory stage to a 32-bit single-port RAM.
// Define MEM_BRIDGE_TIMEOUT_EN to add the TIMEOUT abort path for a stalled memory.
module data_mem_bridge #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    data_mem_bridge_if.slave   bus_io
);
    localparam logic [1:0] MW_BYTE = 2'd0;
    localparam logic [1:0] MW_HALF = 2'd1;
    localparam logic [1:0] MW_WORD = 2'd2;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("data_mem_bridge: TIMEOUT must be in 2..255");
    end

    typedef enum logic [1:0] {IDLE, ADDR, RDATA, DONE} state_e;

    state_e      state_q;
    logic        wr_q;
    logic [1:0]  width_q;
    logic        sgn_q;
    logic [1:0]  off_q;
    logic        err_pend_q;
    logic        ack_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        m_valid_q;
    logic        m_we_q;
    logic [3:0]  m_be_q;
    logic [31:0] m_addr_q;
    logic [31:0] m_wdata_q;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    logic [7:0]  cnt_q;
`endif

    logic        legal_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    function automatic logic [3:0] lane_enables(input logic [1:0] width, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        case (width)
            MW_BYTE: be = 4'b0001 << off;
            MW_HALF: be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] width, input logic [31:0] wd);
        logic [31:0] r;
        r = wd;
        case (width)
            MW_BYTE: r = {4{wd[7:0]}};
            MW_HALF: r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Narrow lanes are shifted down to bit 0 before extension from their top bit.
    function automatic logic [31:0] extend_load(input logic [1:0] width, input logic sgn,
                                                input logic [1:0] off, input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] sx;
        logic [31:0]        res;
        res = word;
        case (width)
            MW_BYTE: begin
                b   = 8'(word >> {off, 3'b000});
                sx  = 32'(b);
                res = sgn ? sx : {24'd0, b};
            end
            MW_HALF: begin
                h   = 16'(word >> {off[1], 4'b0000});
                sx  = 32'(h);
                res = sgn ? sx : {16'd0, h};
            end
            default: res = word;
        endcase
        return res;
    endfunction

    always_comb begin
        legal_d = 1'b0;
        case (bus_io.width)
            MW_BYTE: legal_d = 1'b1;
            MW_HALF: legal_d = ~bus_io.addr[0];
            MW_WORD: legal_d = (bus_io.addr[1:0] == 2'b00);
            default: legal_d = 1'b0;
        endcase
        be_d    = lane_enables(bus_io.width, bus_io.addr[1:0]);
        wdata_d = replicate(bus_io.width, bus_io.wdata);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            width_q    <= MW_BYTE;
            sgn_q      <= 1'b0;
            off_q      <= 2'b00;
            err_pend_q <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            m_valid_q  <= 1'b0;
            m_we_q     <= 1'b0;
            m_be_q     <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus_io.req) begin
                        wr_q       <= bus_io.wr;
                        width_q    <= bus_io.width;
                        sgn_q      <= bus_io.sgn;
                        off_q      <= bus_io.addr[1:0];
                        err_pend_q <= ~legal_d;
                        if (legal_d) begin
                            state_q   <= ADDR;
                            m_valid_q <= 1'b1;
                            m_we_q    <= bus_io.wr;
                            m_be_q    <= be_d;
                            m_addr_q  <= {bus_io.addr[31:2], 2'b00};
                            m_wdata_q <= wdata_d;
`ifdef MEM_BRIDGE_TIMEOUT_EN
                            cnt_q     <= '0;
`endif
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                ADDR: begin
                    if (bus_io.m_ready) begin
                        m_valid_q <= 1'b0;
                        m_we_q    <= 1'b0;
                        state_q   <= wr_q ? DONE : RDATA;
`ifdef MEM_BRIDGE_TIMEOUT_EN
                        cnt_q     <= '0;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        m_valid_q  <= 1'b0;
                        m_we_q     <= 1'b0;
                        err_pend_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
`endif
                    end
                end
                // m_rvalid is only honoured here, never alongside m_ready in ADDR.
                RDATA: begin
                    if (bus_io.m_rvalid) begin
                        rdata_q <= extend_load(width_q, sgn_q, off_q, bus_io.m_rdata);
                        state_q <= DONE;
`ifdef MEM_BRIDGE_TIMEOUT_EN
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        err_pend_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
`endif
                    end
                end
                DONE: begin
                    ack_q   <= 1'b1;
                    err_q   <= err_pend_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_io.ack     = ack_q;
    assign bus_io.err     = err_q;
    assign bus_io.rdata   = rdata_q;
    assign bus_io.m_valid = m_valid_q;
    assign bus_io.m_we    = m_we_q;
    assign bus_io.m_be    = m_be_q;
    assign bus_io.m_addr  = m_addr_q;
    assign bus_io.m_wdata = m_wdata_q;
endmodule

// File: tb/tb_data_mem_bridge.sv
// Randomized scoreboard bench for data_mem_bridge with a behavioural RAM responder.
module tb_data_mem_bridge;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_bridge_if bus();

    data_mem_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          start;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        logic [3:0]  be;
        logic        we;
        int          rstall;
        int          vstall;
        bit          early;
    } mem_t;

    exp_t        sq[$];
    mem_t        mq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] model_rdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic finish_up();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Reference load extension written as integer arithmetic on the selected lane.
    function automatic logic [31:0] ref_load(input int w, input bit s, input logic [1:0] off,
                                             input logic [31:0] word);
        longint v;
        if (w == 0) begin
            v = longint'((word >> (8 * off)) & 32'hFF);
            if (s && v >= 128) v = v - 256;
        end else if (w == 1) begin
            v = longint'((word >> (16 * (off / 2))) & 32'hFFFF);
            if (s && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(word);
        end
        return v[31:0];
    endfunction

    task automatic issue(input bit wr, input logic [1:0] w, input bit s, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word, input int rs, input int vs,
                         input bit early, input bit want_ack, input bit tmo);
        exp_t e;
        mem_t m;
        bit   legal;
        legal = (w == 2'd0) || (w == 2'd1 && a[0] == 1'b0) || (w == 2'd2 && a[1:0] == 2'b00);
        @(negedge clk);
        e.start = cyc;
        e.err   = !legal;
        e.lat   = 1;
        if (legal) begin
            m.addr   = a & 32'hFFFF_FFFC;
            m.we     = wr;
            m.word   = word;
            m.rstall = rs;
            m.vstall = vs;
            m.early  = early;
            m.be     = (w == 2'd0) ? 4'(1 << a[1:0]) : (w == 2'd1) ? 4'(3 << (a[1:0] & 2'b10)) : 4'hF;
            m.wdata  = (w == 2'd0) ? (wd & 32'hFF) * 32'h0101_0101 :
                       (w == 2'd1) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
            if (tmo) begin
                e.err = 1'b1;
                e.lat = TIMEOUT + 1;
            end else begin
                e.lat = wr ? 2 + rs : 3 + rs + vs;
                if (!wr) model_rdata = ref_load(int'(w), s, a[1:0], word);
            end
            mq.push_back(m);
        end
        e.rdata = model_rdata;
        if (want_ack) sq.push_back(e);
        bus.req   = 1'b1;
        bus.wr    = wr;
        bus.width = w;
        bus.sgn   = s;
        bus.addr  = a;
        bus.wdata = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req   = 1'b0;
        bus.wr    = 1'($urandom);
        bus.width = 2'($urandom);
        bus.sgn   = 1'($urandom);
        bus.addr  = $urandom;
        bus.wdata = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sq.size() != 0 || mq.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no completion, scoreboard %0d mem %0d pending", sq.size(), mq.size());
            finish_up();
        end
    endtask

    // Completion monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.ack === 1'b1) begin
                if (sq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected: ack=1 with nothing outstanding at cycle %0d", cyc);
                end else begin
                    e = sq.pop_front();
                    chk("err", 32'(bus.err), 32'(e.err));
                    chk("rdata", bus.rdata, e.rdata);
                    chk("ack_latency", 32'(cyc - e.start - 1), 32'(e.lat));
                    chk("m_valid_at_ack", 32'(bus.m_valid), 32'h0);
                end
            end
        end
    end

    // RAM responder
    initial begin
        mem_t m;
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.m_valid === 1'b1) begin
                if (mq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected: m_valid=1 m_addr=%08h with no access expected", bus.m_addr);
                    bus.m_ready = 1'b1;
                    @(negedge clk);
                    bus.m_ready = 1'b0;
                end else begin
                    m = mq.pop_front();
                    chk("m_addr", bus.m_addr, m.addr);
                    chk("m_be", 32'(bus.m_be), 32'(m.be));
                    chk("m_we", 32'(bus.m_we), 32'(m.we));
                    chk("m_wdata", bus.m_wdata, m.wdata);
                    for (int i = 0; i < m.rstall; i++) begin
                        @(negedge clk);
                        if (bus.m_valid !== 1'b1) break;
                    end
                    if (bus.m_valid === 1'b1) begin
                        chk("m_addr_hold", bus.m_addr, m.addr);
                        bus.m_ready = 1'b1;
                        if (m.early) begin
                            bus.m_rvalid = 1'b1;
                            bus.m_rdata  = ~m.word;
                        end
                        @(negedge clk);
                        bus.m_ready  = 1'b0;
                        bus.m_rvalid = 1'b0;
                        chk("m_valid_drop", 32'(bus.m_valid), 32'h0);
                        if (!m.we) begin
                            repeat (m.vstall) @(negedge clk);
                            bus.m_rvalid = 1'b1;
                            bus.m_rdata  = m.word;
                            @(negedge clk);
                            bus.m_rvalid = 1'b0;
                            bus.m_rdata  = $urandom;
                        end
                    end
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        checks++;
        errors++;
        $display("FAIL watchdog: simulation cycle limit reached");
        finish_up();
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 32'(bus.ack), 32'h0);
        chk({tag, "_err"}, 32'(bus.err), 32'h0);
        chk({tag, "_m_valid"}, 32'(bus.m_valid), 32'h0);
        chk({tag, "_m_we"}, 32'(bus.m_we), 32'h0);
        chk({tag, "_m_be"}, 32'(bus.m_be), 32'h0);
        chk({tag, "_rdata"}, bus.rdata, 32'h0);
        chk({tag, "_m_addr"}, bus.m_addr, 32'h0);
        chk({tag, "_m_wdata"}, bus.m_wdata, 32'h0);
    endtask

    initial begin
        int          r;
        logic [1:0]  w;
        logic [31:0] a;
        bus.req   = 1'b0;
        bus.wr    = 1'b0;
        bus.width = 2'd0;
        bus.sgn   = 1'b0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        issue(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00AB, 32'h0, 0, 0, 1'b0, 1'b1, 1'b0);
        wait_done();
        issue(1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 32'h8001_1234, 0, 0, 1'b0, 1'b1, 1'b0);
        wait_done();
        chk("plan_half_signed", bus.rdata, 32'hFFFF_8001);
        issue(1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 32'h8001_1234, 0, 0, 1'b1, 1'b1, 1'b0);
        wait_done();
        chk("plan_half_unsigned", bus.rdata, 32'h0000_8001);
        issue(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h1234_5678, 0, 0, 1'b0, 1'b1, 1'b0);
        wait_done();
        chk("plan_misaligned_rdata", bus.rdata, 32'h0000_8001);
        issue(1'b1, 2'd3, 1'b0, 32'h0, 32'h5A5A_5A5A, 32'h0, 0, 0, 1'b0, 1'b1, 1'b0);
        wait_done();
`ifdef MEM_BRIDGE_TIMEOUT_EN
        issue(1'b1, 2'd2, 1'b0, 32'h400, 32'hDEAD_BEEF, 32'h0, TIMEOUT + 24, 0, 1'b0, 1'b1, 1'b1);
        wait_done();
`endif

        // Reset while the load waits in RDATA; the late m_rvalid must be ignored.
        issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'hCAFE_F00D, 0, 8, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_rdata", bus.rdata, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h306, 32'h0000_BEEF, 32'h0, 1, 0, 1'b0, 1'b1, 1'b0);
        wait_done();

        for (int t = 0; t < 250; t++) begin
            r = $urandom_range(0, 9);
            w = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a = $urandom;
            if ($urandom_range(0, 3) != 0 && (w == 2'd1 || w == 2'd2))
                a = a & ~((w == 2'd1) ? 32'h1 : 32'h3);
            issue(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        finish_up();
    end
endmodule

// File: doc/data_mem_bridge.md
# data_mem_bridge

Word-wide data-memory bridge between the multi-cycle core's memory stage and a single-port 32-bit data RAM. It accepts one byte, half-word or word load/store per request. It generates word-aligned addresses, byte-lane enables and replicated write data, and it sign- or zero-extends load data. It runs a valid/ready handshake on the memory side and returns a one-cycle completion pulse to the core.

## Interface
- TIMEOUT, 16: cycles the bridge waits for m_ready or m_rvalid before aborting with err (range 2..255).
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  core request; sampled only in IDLE.
- wr  in  1  1 = store (`DATA_ST`), 0 = load (`DATA_LD`).
- width  in  2  `MW_Byte` / `MW_Half` / `MW_Word`; any other code is illegal.
- sgn  in  1  1 = sign-extend load result, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data; the low byte or half carries narrow stores.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; 1 = misaligned, illegal width or timeout.
- rdata  out  32  extended load result; holds until the next load completes.
- m_valid  out  1  memory request valid.
- m_we  out  1  memory write enable.
- m_be  out  4  byte-lane enables; bit i covers byte i (little-endian).
- m_addr  out  32  word address: {addr[31:2], 2'b00}.
- m_wdata  out  32  lane-replicated write data.
- m_ready  in  1  memory accepts the request.
- m_rvalid  in  1  read data valid.
- m_rdata  in  32  read word.

## Operation
- FSM states: IDLE, ADDR, RDATA, DONE.
- IDLE: when req=1, capture wr, width, sgn, addr and wdata into internal registers. Later changes on the core inputs have no effect until the bridge returns to IDLE.
- Legality check at capture:
  - Byte: always legal.
  - Half: addr[0] must be 0.
  - Word: addr[1:0] must be 00.
  - Illegal access or illegal width code goes IDLE→DONE with err=1. No memory access is issued.
- Legal access goes IDLE→ADDR.
- ADDR: m_valid=1 with m_addr, m_we, m_be and m_wdata held stable until m_ready=1.
  - Store: ADDR→DONE.
  - Load: ADDR→RDATA.
- RDATA: m_valid=0. On m_rvalid=1, register the extended result into rdata and go to DONE.
- DONE: ack=1 for exactly one cycle, then IDLE. A req present during DONE is ignored; it is sampled again in IDLE.
- Byte-lane enables:
  - Byte: m_be = 4'b0001 << addr[1:0].
  - Half: m_be = 4'b0011 << {addr[1],1'b0}.
  - Word: m_be = 4'b1111.
  - Loads drive the same enables, informational only.
- Write data:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Load extract:
  - Byte: lane = m_rdata >> (8*addr[1:0]); extend from bit 7.
  - Half: lane = m_rdata >> (16*addr[1]); extend from bit 15.
  - Word: passed through unchanged.
- err is cleared at every ack without an error. rdata is not updated on stores or on errored loads.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; ack, err, m_valid, m_we = 0; m_be = 0; rdata, m_addr, m_wdata = 0; timeout counter = 0.
- Reset release is synchronous to the next posedge.
- Reset mid-transaction: any outstanding memory transaction is abandoned without completion; a late m_rvalid is ignored in IDLE.
- Store latency, req sampled at edge E0:
  - m_valid is high from E0.
  - With m_ready=1 at E1, ack is high between E2 and E3.
  - Minimum store latency: 2 cycles req→ack.
- Load latency: with m_ready at E1 and m_rvalid at E2, rdata and ack are valid between E3 and E4. Minimum: 3 cycles. m_rvalid in the same cycle as m_ready is not accepted; it must arrive in RDATA.
- Error path: ack=err=1 in the cycle after E0.
- Timeout counter: resets on entry to ADDR and to RDATA and increments each waiting cycle. On reaching TIMEOUT, go to DONE with err=1 and drop m_valid.

## Configuration
- MEM_BRIDGE_TIMEOUT_EN defined: timeout counter and the TIMEOUT abort path are present.
- Undefined: the counter is removed; ADDR and RDATA wait indefinitely; err reports only misaligned access or illegal width. TIMEOUT is ignored.

## Test plan
- Store byte, addr=0x103, wdata=0x000000AB → m_addr=0x100, m_be=4'b1000, m_wdata=0xABABABAB, m_we=1; ack 2 cycles after req with m_ready immediate; err=0.
- Load half, sgn=1, addr=0x202, m_rdata=0x80011234 → rdata=0xFFFF8001, ack=1, err=0.
- Same access with sgn=0 → rdata=0x00008001.
- Word load at addr=0x101 → ack=err=1 one cycle after req; m_valid never asserted; rdata unchanged.
- Timeout, TIMEOUT=16, MEM_BRIDGE_TIMEOUT_EN defined, m_ready held 0 → m_valid drops and ack=err=1 after 16 waiting cycles.
- Load at 0x300; rst pulsed low while in RDATA; m_rvalid asserted afterwards → all outputs 0 at once, no ack, state IDLE. The next store completes normally.
